dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Parametrised data memory with valid/ready request and response handshake.
//  Supports byte, half and word loads/stores with sign/zero extension.
//  Misaligned accesses that cross a word boundary are split into two beats by an FSM.
//  Sits between the core's load/store stage and byte-addressed data RAM; replaces the
//  single-cycle combinational-read data memory in the multi-cycle datapath.
// PARAMETERS
//  ADDR_WIDTH  32   byte-address width
//  NUM_WORDS   256  32-bit words of storage; power of 2, >=2
//  PROBE_IDX   16   word index driven on mem_probe (word 16 = byte address 0x40)
// PORTS
//  clk          in   1           clock
//  rstn         in   1           reset, asynchronous, active-low
//  req_valid    in   1           request present
//  req_ready    out  1           block can accept; high only in IDLE
//  req_we       in   1           1=store, 0=load
//  req_addr     in   ADDR_WIDTH  byte address
//  req_size     in   2           00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1           loads: 1=zero-extend, 0=sign-extend
//  req_wdata    in   32          store data; low bytes used per size
//  rsp_valid    out  1           one-cycle response pulse, loads and stores
//  rsp_rdata    out  32          load result; 0 for stores/errors; held until next rsp
//  rsp_err      out  1           request rejected, no memory effect; valid with rsp_valid
//  mem_probe    out  32          continuous view of memory[PROBE_IDX]
// BEHAVIOUR
//  - Reset (async): FSM->IDLE; every memory word=0; rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    req_ready=1 once rstn is high. An in-flight request is dropped with no response.
//  - Word index = addr[2 +: log2(NUM_WORDS)]; upper address bits ignored. Byte offset = addr[1:0].
//  - Byte b (0..N-1, N=1/2/4) targets byte address addr+b, little-endian. It comes from
//    req_wdata[8b+:8] or goes to rdata[8b+:8].
//  - FSM: IDLE -> BEAT0 -> (BEAT1) -> RESP -> IDLE.
//    IDLE: req_ready=1; req_valid high at an edge latches all req_* and moves to BEAT0.
//    BEAT0: at the edge, access word0 (index of addr). Go to BEAT1 if offset+N>4, else RESP.
//    BEAT1: at the edge, access word0+1, wrapping NUM_WORDS-1 -> 0. Go to RESP.
//    RESP: rsp_valid=1 for exactly one cycle; rsp_* are registered. Go to IDLE.
//  - Latency from the accepting edge: rsp_valid is high in the cycle after edge +2 for a
//    single beat, or edge +3 for a split access. Max throughput is 1 req / 3 cycles.
//  - Stores: per-beat byte enables; only the addressed bytes change; other bytes are preserved.
//  - Loads: bytes are collected across beats. At RESP, extend from bit 8N-1 per req_unsigned.
//    Word loads ignore req_unsigned.
//  - req_size=11: no access, BEAT0 goes straight to RESP, rsp_err=1, rsp_rdata=0.
//  - req_* changes while not in IDLE are ignored; the request is latched only at accept.
//  - mem_probe reflects a write on the cycle after the writing edge.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: any access with addr not a multiple of N gets rsp_err=1,
//    rsp_rdata=0 and no memory change, with single-beat latency. BEAT1 is unreachable.
//  MISALIGN_TRAP_EN undefined: misaligned accesses are legal. Within a word they take one
//    beat; across a word boundary they split into two beats.
// TESTING
//  1. sw 0xDEADBEEF @0x40, lw @0x40 -> rsp_rdata=0xDEADBEEF, rsp_err=0, mem_probe=0xDEADBEEF,
//     rsp 2 edges after accept.
//  2. After 1: sb 0x80 @0x41; lb @0x41 -> 0xFFFFFF80; lbu @0x41 -> 0x00000080;
//     lw @0x40 -> 0xDEAD80EF.
//  3. No macro: sw 0x11223344 @0x43 -> rsp 3 edges after accept; lw @0x40 -> 0x44xxxxxx;
//     lw @0x43 -> 0x11223344. With MISALIGN_TRAP_EN: rsp_err=1, lw @0x40 unchanged.
//  4. Wrap (NUM_WORDS=256): sh 0xABCD @0x3FF -> word255[31:24]=0xCD, word0[7:0]=0xAB;
//     lhu @0x3FF -> 0x0000ABCD; lh -> 0xFFFFABCD.
//  5. rstn low during BEAT1 of a split store -> no rsp_valid, req_ready=1 after release,
//     lw anywhere -> 0.
//  6. req_size=11 with req_we=1 @0x40 -> rsp_err=1, rsp_rdata=0, mem_probe unchanged;
//     back-to-back reqs held valid are accepted one per 3 cycles.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: flop-based data memory behind a valid/ready load/store port.
// Byte/half/word accesses with sign or zero extension. An access that crosses
// a word boundary is split into two beats (wrapping at the top of memory).
// Optional build macro: MISALIGN_TRAP_EN -- misaligned accesses are rejected
// with rsp_err instead of being split.
module dmem_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned PROBE_IDX  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           mem_probe
);

  localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
  localparam int unsigned LANES   = 4;
  localparam int unsigned UPPER_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        ld_buf_q, ld_buf_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [31:0]        mem_q [NUM_WORDS];
  logic [31:0]        mem_d [NUM_WORDS];

  logic [3:0]         nbytes_c;
  logic               err_c;
  logic               split_c;
  logic [31:0]        ext_c;
  logic               beat1_c;
  logic               acc_c;
  logic [IDX_W-1:0]   acc_idx_c;
  logic [LANES-1:0]   lane_en_c;
  logic [LANES-1:0][3:0] lane_pos_c;

  // Upper address bits do not select storage.
  logic [UPPER_W-1:0] unused_addr_hi;
  assign unused_addr_hi = req_addr[ADDR_WIDTH-1:IDX_W+2];

  // Decode the latched request: size in bytes, rejection, split, load extension.
  always_comb begin
    nbytes_c = 4'd0;
    case (size_q)
      2'b00:   nbytes_c = 4'd1;
      2'b01:   nbytes_c = 4'd2;
      2'b10:   nbytes_c = 4'd4;
      default: nbytes_c = 4'd0;
    endcase
`ifdef MISALIGN_TRAP_EN
    err_c = (size_q == 2'b11)
          || ((size_q == 2'b01) && off_q[0])
          || ((size_q == 2'b10) && (off_q != 2'b00));
`else
    err_c = (size_q == 2'b11);
`endif
    split_c = !err_c && ((4'(off_q) + nbytes_c) > 4'd4);
    ext_c = ld_buf_q;
    case (size_q)
      2'b00:   ext_c = uns_q ? {24'd0, ld_buf_q[7:0]}
                             : {{24{ld_buf_q[7]}}, ld_buf_q[7:0]};
      2'b01:   ext_c = uns_q ? {16'd0, ld_buf_q[15:0]}
                             : {{16{ld_buf_q[15]}}, ld_buf_q[15:0]};
      default: ext_c = ld_buf_q;
    endcase
  end

  // Per-beat lane map: which word is touched and which request byte each lane carries.
  always_comb begin
    beat1_c    = (state_q == S_BEAT1);
    acc_c      = ((state_q == S_BEAT0) || beat1_c) && !err_c;
    acc_idx_c  = beat1_c ? (idx_q + IDX_W'(1)) : idx_q;
    lane_en_c  = '0;
    lane_pos_c = '0;
    for (int l = 0; l < LANES; l++) begin
      // Lanes below the offset wrap to large values and drop out of the compare.
      lane_pos_c[l] = 4'(l) + (beat1_c ? 4'd4 : 4'd0) - 4'(off_q);
      lane_en_c[l]  = acc_c && (lane_pos_c[l] < nbytes_c);
    end
  end

  // Store path: byte-enabled update of the addressed word.
  always_comb begin
    mem_d = mem_q;
    for (int l = 0; l < LANES; l++) begin
      if (we_q && lane_en_c[l]) begin
        mem_d[acc_idx_c][8*l +: 8] = wdata_q[{lane_pos_c[l][1:0], 3'b000} +: 8];
      end
    end
  end

  // Load path: gather addressed bytes across beats into request byte order.
  always_comb begin
    ld_buf_d = ld_buf_q;
    if ((state_q == S_IDLE) && req_valid) begin
      ld_buf_d = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (!we_q && lane_en_c[l]) begin
        ld_buf_d[{lane_pos_c[l][1:0], 3'b000} +: 8] = mem_q[acc_idx_c][8*l +: 8];
      end
    end
  end

  // FSM next state, request capture and registered response.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    idx_d       = idx_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[2 +: IDX_W];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          state_d = S_BEAT0;
        end
      end
      S_BEAT0: state_d = split_c ? S_BEAT1 : S_RESP;
      S_BEAT1: state_d = S_RESP;
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_c;
        rsp_rdata_d = (err_c || we_q) ? 32'd0 : ext_c;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  // Control, request and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      idx_q       <= '0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      ld_buf_q    <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      ld_buf_q    <= ld_buf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage array, cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '{default: 32'd0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_probe = mem_q[IDX_W'(PROBE_IDX)];

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: vector table plus hand sequences; responses checked from a scoreboard queue.
module tb_dmem_lsu;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_probe;

  dmem_lsu #(.ADDR_WIDTH(32), .NUM_WORDS(256), .PROBE_IDX(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_probe(mem_probe)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          tag;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] er;
    logic        ee;
    int          el;
    logic [31:0] ep;
  } vec_t;

  localparam int NV = 23;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vt[NV];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string what, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s tag=%0d got=%08h want=%08h", what, tag, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", -1, 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rdata", mon_e.tag, rsp_rdata, mon_e.rdata);
        chk("err", mon_e.tag, 32'(rsp_err), 32'(mon_e.err));
        chk("latency", mon_e.tag, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [31:0] er,
                       input logic ee, input int el, input int tag, input bit hold,
                       output int acc);
    int g;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    acc = cyc + 1;
    chk("accept", tag, 32'(req_ready), 32'd1);
    if (req_ready === 1'b1) begin
      e.rdata = er; e.err = ee; e.lat = el; e.acc = acc; e.tag = tag;
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int tag);
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rsp_timeout", tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tag=-1 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int accs[5];
    logic [31:0] p6;
    p6 = TRAP ? 32'hDEAD80EF : 32'h44AD80EF;

    //          we    addr           size  uns   wdata          exp rdata                          err   lat               probe
    vt[0]  = '{1'b1, 32'h0000_0040, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,                             1'b0, 2,                32'hDEADBEEF};
    vt[1]  = '{1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF,                      1'b0, 2,                32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h0000_0041, 2'd0, 1'b0, 32'h12345680, 32'h0,                             1'b0, 2,                32'hDEAD80EF};
    vt[3]  = '{1'b0, 32'h0000_0041, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80,                      1'b0, 2,                32'hDEAD80EF};
    vt[4]  = '{1'b0, 32'h0000_0041, 2'd0, 1'b1, 32'h0,        32'h00000080,                      1'b0, 2,                32'hDEAD80EF};
    vt[5]  = '{1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0,        32'hDEAD80EF,                      1'b0, 2,                32'hDEAD80EF};
    vt[6]  = '{1'b1, 32'h0000_0043, 2'd2, 1'b0, 32'h11223344, 32'h0,                             TRAP, TRAP ? 2 : 3,     p6};
    vt[7]  = '{1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0,        p6,                                1'b0, 2,                p6};
    vt[8]  = '{1'b0, 32'h0000_0043, 2'd2, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'h11223344,       TRAP, TRAP ? 2 : 3,     p6};
    vt[9]  = '{1'b0, 32'h0000_0044, 2'd2, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'h00112233,       1'b0, 2,                p6};
    vt[10] = '{1'b0, 32'h0000_0042, 2'd1, 1'b0, 32'h0,        TRAP ? 32'hFFFFDEAD : 32'h000044AD, 1'b0, 2,               p6};
    vt[11] = '{1'b1, 32'h0000_03FF, 2'd1, 1'b0, 32'h5555ABCD, 32'h0,                             TRAP, TRAP ? 2 : 3,     p6};
    vt[12] = '{1'b0, 32'h0000_03FF, 2'd1, 1'b1, 32'h0,        TRAP ? 32'h0 : 32'h0000ABCD,       TRAP, TRAP ? 2 : 3,     p6};
    vt[13] = '{1'b0, 32'h0000_03FF, 2'd1, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'hFFFFABCD,       TRAP, TRAP ? 2 : 3,     p6};
    vt[14] = '{1'b0, 32'h0000_03FC, 2'd2, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'hCD000000,       1'b0, 2,                p6};
    vt[15] = '{1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'h000000AB,       1'b0, 2,                p6};
    vt[16] = '{1'b0, 32'h0000_03FF, 2'd0, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'hFFFFFFCD,       1'b0, 2,                p6};
    vt[17] = '{1'b1, 32'h0000_0040, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h0,                             1'b1, 2,                p6};
    vt[18] = '{1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0,        p6,                                1'b0, 2,                p6};
    vt[19] = '{1'b0, 32'h0001_0040, 2'd2, 1'b0, 32'h0,        p6,                                1'b0, 2,                p6};
    vt[20] = '{1'b0, 32'h0000_0041, 2'd1, 1'b1, 32'h0,        TRAP ? 32'h0 : 32'h0000AD80,       TRAP, 2,                p6};
    vt[21] = '{1'b0, 32'h0000_03FE, 2'd1, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'hFFFFCD00,       1'b0, 2,                p6};
    vt[22] = '{1'b0, 32'h0000_03FD, 2'd2, 1'b0, 32'h0,        TRAP ? 32'h0 : 32'hABCD0000,       TRAP, TRAP ? 2 : 3,     p6};

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 0, rsp_rdata, 32'd0);
    chk("rst_err", 0, 32'(rsp_err), 32'd0);
    chk("rst_probe", 0, mem_probe, 32'd0);

    for (int i = 0; i < NV; i++) begin
      issue(vt[i].we, vt[i].addr, vt[i].size, vt[i].uns, vt[i].wdata,
            vt[i].er, vt[i].ee, vt[i].el, i, 1'b0, acc);
      wait_idle(i);
      chk("probe", i, mem_probe, vt[i].ep);
    end

    // Reset in the second beat of a split store drops it and clears memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3FE; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
    chk("split_ready", 100, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 100, 32'(rsp_valid), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 100, 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 100, 32'(rsp_valid), 32'd0);
    chk("post_rst_probe", 100, mem_probe, 32'd0);
    issue(1'b0, 32'h40,  2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 2, 101, 1'b0, acc); wait_idle(101);
    issue(1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 2, 102, 1'b0, acc); wait_idle(102);
    issue(1'b0, 32'h0,   2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 2, 103, 1'b0, acc); wait_idle(103);

    // Back-to-back with req_valid held; request fields change while the block is busy.
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'h01020304, 32'h0,        1'b0, 2, 200, 1'b1, accs[0]);
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0,        32'h01020304, 1'b0, 2, 201, 1'b1, accs[1]);
    issue(1'b1, 32'h40, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 2, 202, 1'b1, accs[2]);
    issue(1'b0, 32'h42, 2'd1, 1'b1, 32'h0,        32'h00000102, 1'b0, 2, 203, 1'b1, accs[3]);
    issue(1'b0, 32'h43, 2'd0, 1'b0, 32'h0,        32'h00000001, 1'b0, 2, 204, 1'b0, accs[4]);
    for (int k = 1; k < 5; k++) begin
      chk("b2b_spacing", 200 + k, 32'(accs[k] - accs[k-1]), 32'd3);
    end
    wait_idle(204);
    chk("b2b_probe", 204, mem_probe, 32'h01020304);
    repeat (3) @(negedge clk);
    chk("rdata_held", 205, rsp_rdata, 32'h00000001);
    chk("rsp_one_cycle", 205, 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
